// File: rtl/input_peripherals.sv
// ---------------------------------------------------------------------------
// input_peripherals
//
// Memory-mapped input block for the board's slide switches and push buttons.
// Raw pads are synchronised (2 FF) and debounced per input. Key presses are
// latched into a write-1-to-clear edge register that drives a maskable level
// interrupt. Reads return full 32-bit words; the LSU extracts bytes/halves.
//
// Parameters
//   BASE_SW     switch page base address (4 KiB aligned)
//   BASE_KEY    key page base address (4 KiB aligned)
//   DEB_CYCLES  consecutive stable clocks needed to accept a new level (2..2^20)
//
// Ports
//   i_clk    clock, all state on rising edge
//   i_rstn   asynchronous active-low reset
//   i_sw     raw switch pads, active-high, asynchronous
//   i_key    raw push-button pads, active-low, asynchronous
//   i_we     store strobe
//   i_addr   byte address
//   i_wdata  store data, unshifted
//   i_size   0 = byte, 1 = half, others = word
//   o_rdata  combinational read data
//   o_irq    level interrupt, |(edge & mask)
// ---------------------------------------------------------------------------
module input_peripherals #(
  parameter logic [31:0] BASE_SW    = 32'h1001_1000,
  parameter logic [31:0] BASE_KEY   = 32'h1001_2000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [9:0]  i_sw,
  input  logic [3:0]  i_key,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_size,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam int          NIN      = 14;
  localparam logic [19:0] CNT_LAST = 20'(DEB_CYCLES - 1);

  // Inputs 0..9 are switches, 10..13 are keys inverted to active-high.
  logic [NIN-1:0] pad_raw;
  assign pad_raw = {~i_key, i_sw};

  logic [NIN-1:0] s1_q, s1_d;
  logic [NIN-1:0] s2_q, s2_d;
  logic [NIN-1:0] stable_q, stable_d;
  logic [19:0]    cnt_q [NIN];
  logic [19:0]    cnt_d [NIN];
  logic [3:0]     edge_q, edge_d;
  logic [3:0]     mask_q, mask_d;

  logic           sw_hit;
  logic           key_hit;
  logic [1:0]     reg_sel;
  logic [1:0]     ofs;
  logic           lane0_en;
  logic [3:0]     key_rise;
  logic [3:0]     clr_bits;

  // Offset bits above [3:2] and store data above the implemented nibble
  // have no function in this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, i_addr[11:4], i_wdata[31:4]};

  // ---------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------
  always_comb begin
    s1_d     = pad_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      // Any sample agreeing with the accepted level restarts the count.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Address decode and store lane selection
  // ---------------------------------------------------------------------
  assign sw_hit  = (i_addr & 32'hFFFF_F000) == BASE_SW;
  assign key_hit = (i_addr & 32'hFFFF_F000) == BASE_KEY;
  assign reg_sel = i_addr[3:2];
  assign ofs     = i_addr[1:0];

  // Every implemented register bit lives in byte lane 0, and unshifted
  // store data always carries lane 0's byte in i_wdata[7:0] whenever that
  // lane is enabled, so only the lane-0 enable needs computing.
  always_comb begin
    case (i_size)
      3'd0:    lane0_en = (ofs == 2'd0);
      3'd1:    lane0_en = ~ofs[1];
      default: lane0_en = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Edge capture, W1C and mask register
  // ---------------------------------------------------------------------
  always_comb begin
    key_rise = stable_d[13:10] & ~stable_q[13:10];
    clr_bits = '0;
    if (i_we && key_hit && reg_sel == 2'd1 && lane0_en) begin
      clr_bits = i_wdata[3:0];
    end
    // A new press on the same edge as a clear must not be lost.
    edge_d = (edge_q & ~clr_bits) | key_rise;
    mask_d = mask_q;
    if (i_we && key_hit && reg_sel == 2'd2 && lane0_en) begin
      mask_d = i_wdata[3:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path and interrupt
  // ---------------------------------------------------------------------
  always_comb begin
    o_rdata = '0;
    if (sw_hit) begin
      o_rdata = {22'd0, stable_q[9:0]};
    end else if (key_hit) begin
      case (reg_sel)
        2'd0:    o_rdata = {28'd0, stable_q[13:10]};
        2'd1:    o_rdata = {28'd0, edge_q};
        2'd2:    o_rdata = {28'd0, mask_q};
        default: o_rdata = '0;
      endcase
    end
  end

  assign o_irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_input_peripherals.sv
// ---------------------------------------------------------------------------
// tb_input_peripherals
//
// Directed scenarios with literal expectations, followed by a randomized
// phase. A behavioural model tracks debounce as "length of the current run
// of disagreeing delayed samples" and registers as plain words; one compare
// process checks o_rdata and o_irq against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_input_peripherals;

  localparam int          D        = 4;
  localparam logic [31:0] SW_BASE  = 32'h1001_1000;
  localparam logic [31:0] KEY_BASE = 32'h1001_2000;
  localparam logic [31:0] NO_PAGE  = 32'h1001_3000;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic [9:0]  sw   = '0;
  logic [3:0]  key  = 4'hF;
  logic        we   = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  size = 3'd2;
  logic [31:0] rdata;
  logic        irq;

  int nCompared   = 0;
  int nMismatched = 0;

  input_peripherals #(
    .BASE_SW   (SW_BASE),
    .BASE_KEY  (KEY_BASE),
    .DEB_CYCLES(D)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_sw   (sw),
    .i_key  (key),
    .i_we   (we),
    .i_addr (addr),
    .i_wdata(wdata),
    .i_size (size),
    .o_rdata(rdata),
    .o_irq  (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [13:0] mStable;
  logic [3:0]  mEdge;
  logic [3:0]  mMask;
  logic [13:0] mDelay[$];
  int          mRunStart[14];
  int          mEdgeCount;

  function automatic logic [31:0] expRead(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if ((a & 32'hFFFF_F000) == SW_BASE) r = {22'd0, mStable[9:0]};
    else if ((a & 32'hFFFF_F000) == KEY_BASE) begin
      case (a[3:2])
        2'd0: r = {28'd0, mStable[13:10]};
        2'd1: r = {28'd0, mEdge};
        2'd2: r = {28'd0, mMask};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mStable = '0;
      mEdge   = '0;
      mMask   = '0;
      mDelay.delete();
      mDelay.push_back(14'd0);
      mDelay.push_back(14'd0);
      foreach (mRunStart[i]) mRunStart[i] = -1;
      mEdgeCount = 0;
    end else begin
      logic [13:0] seen;
      logic [13:0] prevStable;
      int          firstLane;
      mEdgeCount++;
      // Value leaving the two-stage synchroniser on this edge.
      seen = mDelay.pop_front();
      mDelay.push_back({~key, sw});
      prevStable = mStable;
      for (int i = 0; i < 14; i++) begin
        if (seen[i] == prevStable[i]) mRunStart[i] = -1;
        else begin
          if (mRunStart[i] < 0) mRunStart[i] = mEdgeCount;
          if (mEdgeCount - mRunStart[i] + 1 == D) begin
            mStable[i]   = seen[i];
            mRunStart[i] = -1;
          end
        end
      end
      if (we && (addr & 32'hFFFF_F000) == KEY_BASE) begin
        case (size)
          3'd0:    firstLane = int'(addr[1:0]);
          3'd1:    firstLane = addr[1] ? 2 : 0;
          default: firstLane = 0;
        endcase
        if (firstLane == 0) begin
          if (addr[3:2] == 2'd1) mEdge = mEdge & ~wdata[3:0];
          if (addr[3:2] == 2'd2) mMask = wdata[3:0];
        end
      end
      mEdge = mEdge | (mStable[13:10] & ~prevStable[13:10]);
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_rdata", rdata, expRead(addr));
    checkOutput("model_irq", {31'd0, irq}, {31'd0, |(mEdge & mMask)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    we = 1'b1; addr = a; wdata = d; size = s;
    applyStimulus(1);
    we = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checkOutput(name, rdata, exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int idx;
    int r;
    logic [31:0] base;

    #1;
    rstn = 1'b0; sw = 10'h3FF; key = 4'h0;
    applyStimulus(3);
    readCheck("rst_sw", SW_BASE, 32'h0);
    readCheck("rst_key0", KEY_BASE, 32'h0);
    checkOutput("rst_irq", {31'd0, irq}, 32'h0);
    applyStimulus(1);
    readCheck("rst_key4", KEY_BASE + 4, 32'h0);

    // Release reset with switches high and keys held.
    rstn = 1'b1;
    applyStimulus(5);
    readCheck("settle_sw_early", SW_BASE, 32'h0);
    applyStimulus(1);
    readCheck("settle_sw", SW_BASE, 32'h3FF);
    readCheck("settle_key0", KEY_BASE, 32'hF);
    applyStimulus(1);
    readCheck("settle_key4", KEY_BASE + 4, 32'hF);
    doStore(KEY_BASE + 4, 32'hF, 3'd2);
    readCheck("clear_all", KEY_BASE + 4, 32'h0);
    key = 4'hF;
    applyStimulus(10);
    readCheck("keys_released", KEY_BASE, 32'h0);

    // Short press on key[1] is filtered.
    key = 4'b1101;
    applyStimulus(3);
    key = 4'hF;
    applyStimulus(10);
    readCheck("glitch_key0", KEY_BASE, 32'h0);
    readCheck("glitch_key4", KEY_BASE + 4, 32'h0);

    // Long press is accepted on the sixth edge.
    key = 4'b1101;
    applyStimulus(5);
    readCheck("press_early", KEY_BASE, 32'h0);
    applyStimulus(1);
    readCheck("press_key0", KEY_BASE, 32'h2);
    readCheck("press_key4", KEY_BASE + 4, 32'h2);
    checkOutput("press_irq_masked", {31'd0, irq}, 32'h0);

    // Interrupt enable and write-1-to-clear.
    doStore(KEY_BASE + 8, 32'h2, 3'd2);
    checkOutput("irq_enabled", {31'd0, irq}, 32'h1);
    doStore(KEY_BASE + 4, 32'h1, 3'd2);
    readCheck("w1c_other_bit", KEY_BASE + 4, 32'h2);
    doStore(KEY_BASE + 4, 32'h2, 3'd2);
    readCheck("w1c_cleared", KEY_BASE + 4, 32'h0);
    checkOutput("irq_cleared", {31'd0, irq}, 32'h0);

    // key[0] debounces on the same edge as a clear of bit 0.
    key = 4'b1100;
    applyStimulus(5);
    doStore(KEY_BASE + 4, 32'h1, 3'd2);
    readCheck("set_beats_clear", KEY_BASE + 4, 32'h1);
    readCheck("two_keys_held", KEY_BASE, 32'h3);
    doStore(KEY_BASE + 4, 32'hF, 3'd2);

    // Byte-lane writes and decode.
    doStore(KEY_BASE + 8, 32'h05, 3'd0);
    readCheck("sb_mask", KEY_BASE + 8, 32'h5);
    doStore(KEY_BASE + 9, 32'hFF, 3'd0);
    readCheck("sb_lane1_ignored", KEY_BASE + 8, 32'h5);
    doStore(KEY_BASE + 10, 32'hF, 3'd1);
    readCheck("sh_high_ignored", KEY_BASE + 8, 32'h5);
    doStore(SW_BASE, 32'hFFFF_FFFF, 3'd2);
    doStore(KEY_BASE, 32'hFFFF_FFFF, 3'd2);
    readCheck("ro_sw", SW_BASE, 32'h3FF);
    readCheck("ro_key0", KEY_BASE, 32'h3);
    applyStimulus(1);
    readCheck("ro_edge", KEY_BASE + 4, 32'h0);
    readCheck("ro_mask", KEY_BASE + 8, 32'h5);
    applyStimulus(1);
    readCheck("key_c", KEY_BASE + 12, 32'h0);
    readCheck("unmapped", NO_PAGE, 32'h0);

    // Switch bounce on sw[9].
    sw[9] = 1'b0;
    applyStimulus(8);
    readCheck("sw9_low", SW_BASE, 32'h1FF);
    for (int k = 0; k < 10; k++) begin
      sw[9] = (k % 2 == 0);
      applyStimulus(2);
    end
    readCheck("bounce_rejected", SW_BASE, 32'h1FF);
    sw[9] = 1'b1;
    applyStimulus(5);
    readCheck("bounce_early", SW_BASE, 32'h1FF);
    applyStimulus(1);
    readCheck("bounce_settled", SW_BASE, 32'h3FF);

    // Randomized phase, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 9);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, 3);
        key[idx] = ~key[idx];
      end
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0:       base = SW_BASE;
        1:       base = NO_PAGE;
        default: base = KEY_BASE;
      endcase
      addr  = base + 32'($urandom_range(0, 31));
      wdata = $urandom;
      size  = 3'($urandom_range(0, 7));
      we    = (r < 3);
      if ($urandom_range(0, 599) == 0) begin
        we = 1'b0;
        rstn = 1'b0;
        applyStimulus(2);
        rstn = 1'b1;
      end
      applyStimulus(1);
    end
    we = 1'b0;
    applyStimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/input_peripherals.md
# input_peripherals

Memory-mapped input block for the slide switches and push buttons, the read-side counterpart to the output peripheral block on the same LSU peripheral bus. Raw pad inputs are synchronised and debounced. The block latches key-press events in a write-1-to-clear capture register and raises a maskable interrupt. It decodes its own 4 KiB pages on `i_addr[31:12]` and returns full 32-bit words; the LSU does byte/half extraction and extension.

## Interface
- `BASE_SW`, default 32'h1001_1000: switch page base, 4 KiB aligned.
- `BASE_KEY`, default 32'h1001_2000: key page base, 4 KiB aligned.
- `DEB_CYCLES`, default 500000: number of consecutive stable clocks required to accept a new input level. Legal range 2..2^20.
- `i_clk`  in  1: single clock; all state is on its rising edge.
- `i_rstn`  in  1: asynchronous, active-low reset.
- `i_sw`  in  10: raw switch pads, active-high, asynchronous to `i_clk`.
- `i_key`  in  4: raw push-button pads, active-low (pressed = 0), asynchronous.
- `i_we`  in  1: store strobe, qualified by page hit.
- `i_addr`  in  32: byte address.
- `i_wdata`  in  32: store data, unshifted (byte lane chosen by `i_addr[1:0]`).
- `i_size`  in  3: 0 = byte, 1 = half, 2 = word; other values are treated as word.
- `o_rdata`  out  32: read data, combinational from address.
- `o_irq`  out  1: level interrupt, equal to `|(r_edge & r_mask)`.

## Operation
- **Input conditioning.** Keys are inverted at the pad to active-high. Each of the 14 inputs then passes through a 2-FF synchroniser (`s1`, `s2`).
- **Debounce, per input.** Each input has a `stable` bit and a 20-bit counter `cnt`.
  - If `s2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEB_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - A glitch shorter than `DEB_CYCLES` clocks never reaches `stable`.
- **Edge capture.** `r_edge[i]` sets on the same edge that `key_stable[i]` goes 0→1. Releases are not captured.
- **Write-1-to-clear.** A store hitting KEY offset 0x4 clears each `r_edge` bit whose `i_wdata` bit is 1 inside the byte-enable mask.
  - The mask follows the standard store rules: SB selects lane `ofs`; SH selects the low or high half by `ofs[1]`; SW selects all lanes.
  - If a set and a clear hit the same bit on the same edge, set wins.
- **Interrupt mask.** `r_mask[3:0]` at KEY offset 0x8 is read/write and is merged by byte-enable mask like an ordinary store. Only bits [3:0] are implemented.
- **Address map.** Page hit is `(i_addr & 32'hFFFF_F000) == BASE`. Register select within the KEY page is `i_addr[3:2]`; higher offset bits are ignored.
  - SW page, any offset: read `{22'd0, sw_stable}`. Writes are ignored.
  - KEY 0x0: read `{28'd0, key_stable}`. Writes are ignored.
  - KEY 0x4: read `{28'd0, r_edge}`. Writes are W1C.
  - KEY 0x8: read `{28'd0, r_mask}`. Writes are R/W.
  - KEY 0xC: reads 0. Writes are ignored.
  - No page hit: `o_rdata = 0`, and writes have no effect.
- **Side effects.** Reads have no side effects.

## Timing
- **Reset (async assert; release synchronous to the first edge after deassert).** All of the following reset to 0, so after reset `o_rdata` is 0 for every address until inputs settle:
  - `s1`, `s2`, `stable`, `cnt`
  - `r_edge`, `r_mask`
  - `o_irq`
- **Input-to-register latency.** A pad change held steady becomes visible in `stable` exactly 2 + `DEB_CYCLES` rising edges after the first edge that samples it into `s1`.
- **Edge and interrupt timing.** `r_edge` and `o_irq` update on that same edge.
- **Read path.** `o_rdata` is combinational from `i_addr` and the current registers, so a read returns the value as of the last edge. No handshake; zero wait states.
- **Write timing.** W1C and mask writes take effect on the edge where `i_we` is high. `o_irq` reflects the new mask or edge value right after that edge.
- **Bounce during counting.** If an input bounces back to the `stable` value mid-count, `cnt` returns to 0; a full `DEB_CYCLES` run is required again.
- **Reset mid-count.** Reset during a count discards the count and any pending edge.
- **Post-reset settling.** A switch that is already high at reset release shows 1 after 2 + `DEB_CYCLES` clocks.
- **Keys held through reset.** A key held down at reset release produces one `r_edge` set once it debounces. Software clears it after reset.

## Test plan
All scenarios use `DEB_CYCLES=4` unless stated.
- **Reset values.** Assert `i_rstn=0` with `i_sw=10'h3FF` and `i_key=4'h0` → all reads are 0 and `o_irq=0`. Release reset → SW read = 32'h3FF and KEY 0x0 = 32'hF exactly 6 edges later, KEY 0x4 = 32'hF.
- **Key glitch rejection.** Press `key[1]` (drive 0) for 3 clocks, then release → KEY 0x0 and KEY 0x4 stay 0.
  - Then hold it for 10 clocks → KEY 0x0 = 32'h2 on the 6th edge, KEY 0x4 = 32'h2.
  - `o_irq` stays 0 while mask = 0.
- **Interrupt and W1C.** SW 32'h2 to KEY 0x8 → `o_irq=1` on the next edge.
  - SW 32'h1 to KEY 0x4 → edge still 32'h2.
  - SW 32'h2 to KEY 0x4 → edge = 0 and `o_irq=0` after that edge.
- **Set beats clear.** Arrange for a `key[0]` debounce rise on the same edge as SW 32'h1 to KEY 0x4 → KEY 0x4 bit 0 = 1 afterwards.
- **Byte-lane writes and decode.** SB 8'h05 to KEY 0x8 → mask = 32'h5.
  - SB 8'hFF to KEY 0x9 → mask unchanged at 32'h5.
  - SW to the SW page and to KEY 0x0 → no change to any register.
  - Read KEY 0xC and an unmapped address → 0.
- **Switch bounce.** Toggle `sw[9]` every 2 clocks for 20 clocks, then hold it at 1 → SW read bit 9 rises exactly 6 edges after the final transition. Other bits are unaffected.
